// File: rtl/apb_master_pkg.sv
// Shared types and widths for the APB requester: FSM state encoding and the response payload.
package apb_master_pkg;

   localparam int unsigned TIMEOUT_W  = 8;
   // Widest read data the response payload carries; DATA_WIDTH must not exceed it.
   localparam int unsigned RSP_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_e;

   typedef struct packed {
      logic [RSP_DATA_W-1:0] rdata;
      logic                  error;
      logic                  timeout;
   } rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Request/response handshake plus APB bus signals of the requester.
// The master modport is the requester's view; the slave modport is its surroundings.
interface apb_master_if #(
   parameter int unsigned ADDR_WIDTH = 1,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_write;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_error;
   logic                  rsp_timeout;

   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

   modport slave (
      output req_valid, req_addr, req_write, req_wdata, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

endinterface

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS wait cycles; expired_c flags the wait cycle that would reach TIMEOUT_CYCLES.
module apb_timeout_counter
   import apb_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] count_q;
   logic [TIMEOUT_W-1:0] count_d;

   // Expiry is flagged during the last permitted wait so the abort lands after exactly TIMEOUT_CYCLES.
   assign expired_c = enable && (count_q == LAST_WAIT);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired_c) begin
         count_d = count_q + TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/apb_master.sv
// APB requester: takes single commands on a valid/ready port, runs SETUP/ACCESS on APB,
// and returns read data and error status on a valid/ready response port, with an ACCESS timeout.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 1,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic          PCLK,
   input logic          PRESET,
   apb_master_if.master bus
);

   state_e                state_q,     state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   rsp_t                  rsp_q,       rsp_d;
   logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
   logic                  pwrite_q,    pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
   logic                  psel_q,      psel_d;
   logic                  penable_q,   penable_d;

   logic req_ready_c;
   logic accept_c;
   logic cnt_clear_c;
   logic cnt_en_c;
   logic expired_c;

   // A response being consumed this cycle frees the requester, so a new command can ride the same edge.
   assign req_ready_c = !PRESET && (req_ready_q || (rsp_valid_q && bus.rsp_ready));
   assign accept_c    = bus.req_valid && req_ready_c;

   assign cnt_clear_c = (state_q != ACCESS);
   assign cnt_en_c    = (state_q == ACCESS) && !bus.PREADY;

   apb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (PCLK),
      .rst      (PRESET),
      .clear    (cnt_clear_c),
      .enable   (cnt_en_c),
      .expired_c(expired_c)
   );

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      psel_d      = psel_q;
      penable_d   = penable_q;

      unique case (state_q)
         IDLE: ;
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // PREADY wins over a timeout expiring on the same cycle.
            if (bus.PREADY) begin
               rsp_d.rdata   = pwrite_q ? '0 : RSP_DATA_W'(bus.PRDATA);
               rsp_d.error   = bus.PSLVERR;
               rsp_d.timeout = 1'b0;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else if (expired_c) begin
               rsp_d.rdata   = '0;
               rsp_d.error   = 1'b1;
               rsp_d.timeout = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Acceptance is only possible from IDLE or a consumed RESP.
      if (accept_c) begin
         paddr_d  = bus.req_addr;
         pwrite_d = bus.req_write;
         pwdata_d = bus.req_wdata;
         psel_d   = 1'b1;
         state_d  = SETUP;
      end

      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
      end
   end

   assign bus.req_ready   = req_ready_c;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
   assign bus.rsp_error   = rsp_q.error;
   assign bus.rsp_timeout = rsp_q.timeout;
   assign bus.PADDR       = paddr_q;
   assign bus.PSEL        = psel_q;
   assign bus.PENABLE     = penable_q;
   assign bus.PWRITE      = pwrite_q;
   assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: behavioural APB slave with programmable wait states,
// directed scenarios followed by randomized transfers checked against a transfer-level model.
module tb_apb_master;

   localparam int unsigned AW  = 1;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_master #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .PCLK  (clk),
      .PRESET(rst),
      .bus   (bus.master)
   );

   int checks = 0;
   int errors = 0;

   // Slave: ready after slv_waits low ACCESS cycles; drives noise on PREADY/PRDATA/PSLVERR otherwise.
   int          slv_waits = 0;
   logic [31:0] slv_rdata = '0;
   logic        slv_err   = 1'b0;
   int          acc_cnt   = 0;
   bit          noise     = 1'b0;
   bit   [31:0] junk      = '0;
   logic        slv_ready;
   bit          pend      = 1'b0;

   assign slv_ready   = bus.PSEL && bus.PENABLE && (acc_cnt == slv_waits);
   assign bus.PREADY  = (bus.PSEL && bus.PENABLE) ? slv_ready : noise;
   assign bus.PRDATA  = slv_ready ? slv_rdata : junk;
   assign bus.PSLVERR = slv_ready ? slv_err : noise;

   always @(posedge clk) acc_cnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? acc_cnt + 1 : 0;
   always @(negedge clk) begin
      noise <= 1'($urandom);
      junk  <= $urandom;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transfer. Called and returns at a falling edge. chain leaves the response pending.
   task automatic do_txn(input logic [0:0] a, input logic w, input logic [31:0] wd,
                         input logic [31:0] rd, input logic er, input int waits,
                         input int hold, input bit chain);
      bit          tmo, first_ok, stable, held, was_pend;
      int          acc, n_wait, rsp_j, psel_n, pen_n;
      logic [31:0] e_rdata;
      logic        e_err;

      tmo      = (waits >= int'(TMO));
      acc      = tmo ? int'(TMO) : waits + 1;
      e_rdata  = (tmo || w) ? 32'h0 : rd;
      e_err    = tmo ? 1'b1 : er;
      was_pend = pend;

      slv_waits     = waits;
      slv_rdata     = rd;
      slv_err       = er;
      bus.req_addr  = a;
      bus.req_write = w;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      n_wait = 0;
      #1;
      while (!bus.req_ready && n_wait < 40) begin
         @(negedge clk);
         n_wait++;
         #1;
      end
      if (was_pend) check("b2b_accept_wait", 32'(n_wait), 32'd0);
      check("accept", 32'(bus.req_ready), 32'd1);
      if (!bus.req_ready) begin
         bus.req_valid = 1'b0;
         bus.rsp_ready = 1'b0;
         pend = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;

      first_ok = bus.PSEL && !bus.PENABLE && !bus.rsp_valid;
      rsp_j = 0; psel_n = 0; pen_n = 0; stable = 1'b1;
      for (int j = 1; j <= int'(TMO) + 20; j++) begin
         if (j > 1) @(negedge clk);
         if (bus.rsp_valid) begin
            rsp_j = j;
            break;
         end
         if (bus.PSEL) begin
            psel_n++;
            if (bus.PADDR !== a || bus.PWRITE !== w || bus.PWDATA !== wd) stable = 1'b0;
         end
         if (bus.PENABLE) pen_n++;
      end
      check("setup_phase", 32'(first_ok), 32'd1);
      check("rsp_cycle", 32'(rsp_j), 32'(acc + 2));
      check("psel_cycles", 32'(psel_n), 32'(acc + 1));
      check("penable_cycles", 32'(pen_n), 32'(acc));
      check("ctrl_stable", 32'(stable), 32'd1);
      check("rsp_psel_low", 32'({bus.PSEL, bus.PENABLE}), 32'd0);
      check("rsp_rdata", bus.rsp_rdata, e_rdata);
      check("rsp_error", 32'(bus.rsp_error), 32'(e_err));
      check("rsp_timeout", 32'(bus.rsp_timeout), 32'(tmo));

      held = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_rdata !== e_rdata || bus.rsp_error !== e_err ||
             bus.rsp_timeout !== tmo) held = 1'b0;
      end
      if (hold > 0) check("rsp_hold", 32'(held), 32'd1);

      if (chain) begin
         pend = 1'b1;
      end else begin
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
         check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
         check("idle_ready", 32'(bus.req_ready), 32'd1);
         pend = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit seen;
      int n_wait;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.req_addr  = '0;
      bus.req_write = 1'b0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);

      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_psel_penable", 32'({bus.PSEL, bus.PENABLE}), 32'd0);
      check("rst_paddr_pwrite", 32'({bus.PADDR, bus.PWRITE}), 32'd0);
      check("rst_pwdata", bus.PWDATA, 32'd0);
      check("rst_rsp_fields", bus.rsp_rdata | 32'({bus.rsp_error, bus.rsp_timeout}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed scenarios
      do_txn(1'b0, 1'b0, 32'h0, 32'hCAFE_0001, 1'b0, 0, 0, 1'b0);
      do_txn(1'b1, 1'b1, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 1'b1, 0, 0, 1'b0);
      do_txn(1'b1, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 3, 0, 1'b0);
      do_txn(1'b0, 1'b0, 32'h0, 32'h7777_0000, 1'b0, 1000, 0, 1'b0);
      do_txn(1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b1, int'(TMO) - 1, 0, 1'b0);
      do_txn(1'b0, 1'b1, 32'hAAAA_5555, 32'h0, 1'b0, int'(TMO), 0, 1'b0);
      do_txn(1'b0, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0, 1, 5, 1'b1);
      do_txn(1'b1, 1'b1, 32'h0F0F_F0F0, 32'h0, 1'b0, 0, 0, 1'b0);

      // Reset pulse while stuck in ACCESS
      slv_waits     = 1000;
      bus.req_addr  = 1'b1;
      bus.req_write = 1'b0;
      bus.req_valid = 1'b1;
      n_wait = 0;
      #1;
      while (!bus.req_ready && n_wait < 40) begin
         @(negedge clk);
         n_wait++;
         #1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_access_penable", 32'({bus.PSEL, bus.PENABLE}), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_bus_low", 32'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 32'd0);
      check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.PSEL) seen = 1'b1;
      end
      check("no_rsp_after_rst", 32'(seen), 32'd0);
      do_txn(1'b0, 1'b0, 32'h0, 32'h600D_600D, 1'b0, 2, 1, 1'b0);

      // Randomized transfers
      for (int i = 0; i < 24; i++) begin
         logic [0:0]  a;
         logic        w, er;
         logic [31:0] wd, rd;
         int          waits, hold;
         bit          chain;
         a     = 1'($urandom);
         w     = 1'($urandom);
         er    = 1'($urandom);
         wd    = $urandom;
         rd    = $urandom;
         waits = ($urandom_range(0, 6) == 0) ? int'(TMO) + int'($urandom_range(0, 4))
                                             : int'($urandom_range(0, 5));
         hold  = int'($urandom_range(0, 3));
         chain = 1'($urandom);
         do_txn(a, w, wd, rd, er, waits, hold, chain);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
